// File: rtl/id_ex_stage_pkg.sv
// Control-bundle widths, bit positions and ALUControl encodings shared by decoder, ID/EX and ALU.
// Pure declarations: no latency, no flow control.
package id_ex_stage_pkg;

  localparam int WB_W = 2;
  localparam int M_W  = 2;
  localparam int EX_W = 6;

  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int WB_REGWRITE = 1;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7,
    ALU_NOR = 4'hc
  } alu_ctrl_e;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detector: a load in EX whose nonzero rt matches either ID source register.
// Combinational, zero latency; result feeds the stall and bubble logic.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              load_use
);

  // rt is compared even when the ID instruction does not read it; an extra stall is harmless
  assign load_use = ex_valid & ex_memread & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush; one-cycle latency ID -> EX.
// hold_i freezes everything; stall_o (combinational) asks PC and IF/ID to freeze for one cycle.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic [WB_W-1:0]   id_wb_i,
  input  logic [M_W-1:0]    id_m_i,
  input  logic [EX_W-1:0]   id_ex_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [REG_AW-1:0] id_shamt_i,
  output logic              ex_valid_o,
  output logic [WB_W-1:0]   ex_wb_o,
  output logic [M_W-1:0]    ex_m_o,
  output logic [EX_W-1:0]   ex_ex_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [REG_AW-1:0] ex_shamt_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  ctrl_t ctrl_q;
  logic  load_use;
  logic  bubble;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid   (ex_valid_o),
    .ex_memread (ctrl_q.m[M_MEMREAD]),
    .ex_rt      (ex_rt_o),
    .id_rs      (id_rs_i),
    .id_rt      (id_rt_i),
    .load_use   (load_use)
  );

  // A flush already creates the bubble, so the stall is dropped to avoid a second one
  assign stall_o = load_use & ~flush_i;
  assign bubble  = flush_i | load_use;

  assign ex_wb_o = ctrl_q.wb;
  assign ex_m_o  = ctrl_q.m;
  assign ex_ex_o = ctrl_q.ex;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o   <= 1'b0;
      ctrl_q       <= '0;
      ex_pc4_o     <= '0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
      ex_rd_o      <= '0;
      ex_shamt_o   <= '0;
      bubble_cnt_o <= '0;
    end else if (!hold_i) begin
      ex_pc4_o     <= id_pc4_i;
      ex_rs_data_o <= id_rs_data_i;
      ex_rt_data_o <= id_rt_data_i;
      ex_imm_o     <= id_imm_i;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
      ex_rd_o      <= id_rd_i;
      ex_shamt_o   <= id_shamt_i;
      if (bubble) begin
        ex_valid_o <= 1'b0;
        ctrl_q     <= '0;
        if (bubble_cnt_o != '1)
          bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end else begin
        ex_valid_o <= 1'b1;
        ctrl_q     <= '{wb: id_wb_i, m: id_m_i, ex: id_ex_i};
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use, no-hazard, flush+load-use, hold, saturation.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold_i, flush_i;
  logic [WB_W-1:0]   id_wb_i;
  logic [M_W-1:0]    id_m_i;
  logic [EX_W-1:0]   id_ex_i;
  logic [DATA_W-1:0] id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [REG_AW-1:0] id_rs_i, id_rt_i, id_rd_i, id_shamt_i;
  logic              ex_valid_o;
  logic [WB_W-1:0]   ex_wb_o;
  logic [M_W-1:0]    ex_m_o;
  logic [EX_W-1:0]   ex_ex_o;
  logic [DATA_W-1:0] ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [REG_AW-1:0] ex_rs_o, ex_rt_o, ex_rd_o, ex_shamt_o;
  logic              stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  localparam logic [WB_W-1:0] WB_LW  = (2'b1 << WB_REGWRITE) | 2'b01;
  localparam logic [WB_W-1:0] WB_ALU = (2'b1 << WB_REGWRITE);
  localparam logic [M_W-1:0]  M_LW   = (2'b1 << M_MEMREAD);
  localparam logic [M_W-1:0]  M_SW   = (2'b1 << M_MEMWRITE);
  localparam logic [EX_W-1:0] EX_LW  = {2'b01, ALU_ADD};
  localparam logic [EX_W-1:0] EX_ADD = {2'b10, ALU_ADD};
  localparam logic [EX_W-1:0] EX_SUB = {2'b10, ALU_SUB};

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
    .id_wb_i(id_wb_i), .id_m_i(id_m_i), .id_ex_i(id_ex_i),
    .id_pc4_i(id_pc4_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
    .id_imm_i(id_imm_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_shamt_i(id_shamt_i),
    .ex_valid_o(ex_valid_o), .ex_wb_o(ex_wb_o), .ex_m_o(ex_m_o), .ex_ex_o(ex_ex_o),
    .ex_pc4_o(ex_pc4_o), .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
    .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .ex_shamt_o(ex_shamt_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [WB_W-1:0] wb, input logic [M_W-1:0] m,
                        input logic [EX_W-1:0] ex, input logic [DATA_W-1:0] pc4,
                        input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                        input logic [REG_AW-1:0] rd);
    id_wb_i      = wb;
    id_m_i       = m;
    id_ex_i      = ex;
    id_pc4_i     = pc4;
    id_rs_data_i = pc4 ^ 32'h1111_0000;
    id_rt_data_i = pc4 ^ 32'h2222_0000;
    id_imm_i     = pc4 + 32'd4;
    id_rs_i      = rs;
    id_rt_i      = rt;
    id_rd_i      = rd;
    id_shamt_i   = rd ^ 5'd3;
    #1;
  endtask

  initial begin
    rst = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
    set_id('0, '0, '0, '0, '0, '0, '0);
    #12;
    check("rst_valid", 32'(ex_valid_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_cnt", 32'(bubble_cnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // lw $t0, 4($sp) enters EX
    tick();
    set_id(WB_LW, M_LW, EX_LW, 32'h104, 5'd29, 5'd8, 5'd0);
    tick();
    check("lw_valid", 32'(ex_valid_o), 32'd1);
    check("lw_m", 32'(ex_m_o), 32'(M_LW));
    check("lw_rt", 32'(ex_rt_o), 32'd8);
    check("lw_ex", 32'(ex_ex_o), 32'(EX_LW));
    check("lw_imm", ex_imm_o, 32'h108);

    // dependent add in ID: one-cycle stall then one bubble
    set_id(WB_ALU, 2'b00, EX_ADD, 32'h108, 5'd8, 5'd9, 5'd10);
    check("lu_stall", 32'(stall_o), 32'd1);
    tick();
    check("lu_bub_valid", 32'(ex_valid_o), 32'd0);
    check("lu_bub_wb", 32'(ex_wb_o), 32'd0);
    check("lu_bub_m", 32'(ex_m_o), 32'd0);
    check("lu_cnt", 32'(bubble_cnt_o), 32'd1);
    check("lu_stall_drop", 32'(stall_o), 32'd0);
    tick();
    check("add_valid", 32'(ex_valid_o), 32'd1);
    check("add_rs", 32'(ex_rs_o), 32'd8);
    check("add_wb", 32'(ex_wb_o), 32'(WB_ALU));
    check("add_rd", 32'(ex_rd_o), 32'd10);
    check("add_rsdata", ex_rs_data_o, 32'h1111_0108);
    check("add_cnt", 32'(bubble_cnt_o), 32'd1);

    // lw rt=8 then independent rs=9, rt=10
    set_id(WB_LW, M_LW, EX_LW, 32'h10c, 5'd29, 5'd8, 5'd0);
    check("nh_lw_stall", 32'(stall_o), 32'd0);
    tick();
    set_id(WB_ALU, 2'b00, EX_SUB, 32'h110, 5'd9, 5'd10, 5'd11);
    check("nh_stall", 32'(stall_o), 32'd0);
    tick();
    check("nh_valid", 32'(ex_valid_o), 32'd1);
    check("nh_rs", 32'(ex_rs_o), 32'd9);
    check("nh_ex", 32'(ex_ex_o), 32'(EX_SUB));
    check("nh_cnt", 32'(bubble_cnt_o), 32'd1);

    // lw with rt=$0 never stalls
    set_id(WB_LW, M_LW, EX_LW, 32'h114, 5'd0, 5'd0, 5'd0);
    tick();
    set_id(WB_ALU, 2'b00, EX_ADD, 32'h118, 5'd0, 5'd0, 5'd12);
    check("rt0_stall", 32'(stall_o), 32'd0);
    tick();
    check("rt0_valid", 32'(ex_valid_o), 32'd1);
    check("rt0_pc4", ex_pc4_o, 32'h118);

    // flush coincident with load-use: no stall, single bubble
    set_id(WB_LW, M_LW, EX_LW, 32'h11c, 5'd29, 5'd8, 5'd0);
    tick();
    set_id(WB_ALU, 2'b00, EX_ADD, 32'h120, 5'd8, 5'd8, 5'd13);
    flush_i = 1'b1;
    #1;
    check("fl_stall", 32'(stall_o), 32'd0);
    tick();
    flush_i = 1'b0;
    #1;
    check("fl_valid", 32'(ex_valid_o), 32'd0);
    check("fl_m", 32'(ex_m_o), 32'd0);
    check("fl_cnt", 32'(bubble_cnt_o), 32'd2);
    check("fl_stall_after", 32'(stall_o), 32'd0);

    // store in EX, then hold for 3 cycles with ID changing (and a flush during hold)
    set_id(2'b00, M_SW, EX_LW, 32'h200, 5'd4, 5'd5, 5'd0);
    tick();
    check("sw_m", 32'(ex_m_o), 32'(M_SW));
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(WB_ALU, 2'b00, EX_ADD, 32'h300 + 32'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3));
      flush_i = (i == 1);
      tick();
      check("hold_pc4", ex_pc4_o, 32'h200);
      check("hold_valid", 32'(ex_valid_o), 32'd1);
      check("hold_cnt", 32'(bubble_cnt_o), 32'd2);
    end
    hold_i = 1'b0;
    flush_i = 1'b0;
    set_id(WB_ALU, 2'b00, EX_SUB, 32'h400, 5'd6, 5'd7, 5'd8);
    tick();
    check("rel_pc4", ex_pc4_o, 32'h400);
    check("rel_shamt", 32'(ex_shamt_o), 32'd11);
    check("rel_rtdata", ex_rt_data_o, 32'h2222_0400);

    // saturation: 20 flushed bubbles starting from count 2
    flush_i = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("sat_14", 32'(bubble_cnt_o), 32'd14);
    for (int i = 0; i < 8; i++) tick();
    check("sat_15", 32'(bubble_cnt_o), 32'd15);
    flush_i = 1'b0;

    // asynchronous reset mid-stream
    set_id(WB_LW, M_LW, EX_LW, 32'h500, 5'd29, 5'd8, 5'd0);
    tick();
    check("pre_rst_valid", 32'(ex_valid_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(ex_valid_o), 32'd0);
    check("arst_wb", 32'(ex_wb_o), 32'd0);
    check("arst_pc4", ex_pc4_o, 32'd0);
    check("arst_cnt", 32'(bubble_cnt_o), 32'd0);
    check("arst_stall", 32'(stall_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid", 32'(ex_valid_o), 32'd1);
    check("post_rst_pc4", ex_pc4_o, 32'h500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection, bubble insertion and flush handling. Sits directly downstream of the ID-stage control decoder: it captures the decoder's WB/M/EX control bundles plus the ID operands each cycle and presents them to the EX stage. It also raises the stall that freezes the PC and IF/ID register.

## Interface
Parameters:
- DATA_W, 32, datapath width (operands, PC+4, immediate)
- REG_AW, 5, register-specifier width
- CNT_W, 16, width of the bubble performance counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- hold_i  in  1  global freeze (e.g. memory wait); register keeps its contents
- flush_i  in  1  branch/jump redirect; the ID contents this cycle are discarded
- id_wb_i  in  2  {RegWrite, MemtoReg} from decoder
- id_m_i  in  2  {MemRead, MemWrite} from decoder
- id_ex_i  in  6  {RegDst, ALUSrc, ALUControl[3:0]} from decoder
- id_pc4_i  in  DATA_W  PC+4 of the ID instruction
- id_rs_data_i, id_rt_data_i  in  DATA_W  register-file read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_rs_i, id_rt_i, id_rd_i, id_shamt_i  in  REG_AW  instruction fields
- ex_valid_o  out  1  EX-stage slot holds a real instruction
- ex_wb_o, ex_m_o  out  2  registered bundles
- ex_ex_o  out  6  registered bundle
- ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DATA_W  registered data
- ex_rs_o, ex_rt_o, ex_rd_o, ex_shamt_o  out  REG_AW  registered fields
- stall_o  out  1  load-use stall request to PC and IF/ID (combinational)
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

## Operation
- Load-use detect (combinational): load_use = ex_valid_o & ex_m_o[1] & (ex_rt_o != 0) & ((ex_rt_o == id_rs_i) | (ex_rt_o == id_rt_i)). Both sources are compared without regard to whether the ID instruction reads rt, which may produce extra stalls.
- stall_o = load_use & ~flush_i.
- Per-edge update, priority highest first:
  - rst: all outputs and the counter are cleared to 0.
  - hold_i: all registers keep their values. The counter does not change.
  - flush_i: bubble. valid=0, wb=0, m=0, ex=0. Data fields load from ID (don't-care).
  - load_use: bubble, same as flush.
  - otherwise: load all ID inputs; valid=1.
- A bubble always forces RegWrite=0, MemRead=0 and MemWrite=0, so it has no architectural effect.
- bubble_cnt_o increments on every edge that inserts a bubble and hold_i is low. It saturates at 2^CNT_W−1 and does not wrap.
- No arithmetic is performed on data. Widths pass straight through.

## Timing
- Reset value of every output is 0, including ex_valid_o, stall_o (follows from ex_valid_o=0) and bubble_cnt_o.
- Latency: ID inputs at edge N appear on ex_* after edge N. stall_o depends on the current ex_* state and the current ID inputs in the same cycle, with no register in the path.
- Load-use: the lw is in EX at cycle N and the dependent instruction is in ID at cycle N. stall_o is high in cycle N and a bubble enters EX at edge N+1. At that point ex_valid_o=0, so stall_o drops in cycle N+1 and the dependent instruction enters EX at edge N+2. Exactly one bubble is inserted per load-use.
- flush_i together with load_use in the same cycle: stall_o=0, one bubble, counter +1 (not +2).
- hold_i together with flush_i: hold wins. The flush source must keep flush_i asserted until hold_i deasserts.
- rst asserted mid-operation: outputs clear immediately (asynchronously). Operation resumes on the first edge after rst deasserts.
- A lw with rt=$0 never stalls.

## Structure
- Shared package: bundle widths (WB_W=2, M_W=2, EX_W=6), bit indices (M_MEMREAD=1, M_MEMWRITE=0, WB_REGWRITE=1) and the ALUControl encodings shared with the decoder and the ALU.
- One sub-module: hazard_detect. It is purely combinational: it takes ex_valid, ex_memread, ex_rt, id_rs and id_rt and produces load_use. id_ex_stage instantiates it and holds all state.

## Test plan
- Reset: assert rst mid-stream with ex_valid_o=1 → all outputs 0 immediately, bubble_cnt_o=0.
- Load-use: lw $t0 (rt=8) in EX, add with rs=8 in ID → stall_o=1 for one cycle, then ex_valid_o=0 and ex_wb_o=0; add enters EX the next edge; bubble_cnt_o=1.
- No hazard: lw rt=8 in EX, ID rs=9, rt=10 → stall_o=0, ID instruction loads with valid=1. Also lw rt=0 with ID rs=0 → no stall.
- Flush plus load-use in the same cycle → stall_o=0, a single bubble, counter +1.
- hold_i for 3 cycles with ID inputs changing → ex_* unchanged and counter unchanged. After release, normal loading resumes.
- Saturation: CNT_W=4, force 20 bubbles → bubble_cnt_o stops at 15.
